// File: rtl/lcd_pkg.sv
// Shared LCD host-port types: the 9-bit {rs, data} transaction and arbiter states.
package lcd_pkg;

  localparam int unsigned LCD_TXN_W  = 9;
  localparam int unsigned LCD_RS_BIT = 8;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_txn_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/lcd_txn_arbiter_if.sv
// Requester-side and LCD-host-side handshake bundle for the LCD transaction arbiter.
interface lcd_txn_arbiter_if
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ = 3
);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*LCD_TXN_W-1:0] req_txn;
  logic [N_REQ-1:0]           req_last;
  logic [N_REQ-1:0]           req_ready;
  logic                       host_valid;
  logic                       host_rs;
  logic [7:0]                 host_data;
  logic                       host_ready;

  // master: the arbiter; slave: requesters plus LCD controller host side
  modport master (
    input  req_valid, req_txn, req_last, host_ready,
    output req_ready, host_valid, host_rs, host_data
  );

  modport slave (
    output req_valid, req_txn, req_last, host_ready,
    input  req_ready, host_valid, host_rs, host_data
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set req bit searching upward from last_grant+1 with wrap.
module rr_priority_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    idx     = 0;
    for (int unsigned k = N; k >= 1; k--) begin
      idx = (32'(last_grant) + k) % N;
      if (req[IW'(idx)]) begin
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/lcd_txn_arbiter.sv
// Round-robin, packet-locked arbiter sharing the HD44780 host port among N_REQ requesters,
// with a watchdog that releases a lock stalled mid-packet.
module lcd_txn_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned LOCK_TIMEOUT = 50_000_000
) (
  input  logic                     MAX10_CLK1_50,
  input  logic                     rst_n,
  input  logic                     init_done,
  lcd_txn_arbiter_if.master        bus,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_pulse
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT);

  localparam logic [0:0] ST_IDLE   = ARB_IDLE;
  localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          tmo_q, tmo_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;

  lcd_txn_t      sel_txn;
  logic          sel_valid;
  logic          sel_last;
  logic          active;

  rr_priority_pick #(
    .N (N_REQ)
  ) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // State register.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(N_REQ - 1);
      wd_cnt_q     <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  // Next-state, watchdog and pass-through datapath from the granted requester.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    wd_cnt_d       = wd_cnt_q;
    tmo_d          = 1'b0;
    sel_txn        = '0;
    sel_valid      = 1'b0;
    sel_last       = 1'b0;
    bus.req_ready  = '0;
    bus.host_valid = 1'b0;
    bus.host_rs    = 1'b0;
    bus.host_data  = '0;

    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == IW'(i)) begin
        sel_txn   = lcd_txn_t'(bus.req_txn[i*LCD_TXN_W +: LCD_TXN_W]);
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
      end
    end

    // init_done gates the LCD side entirely so nothing moves while the controller initialises.
    active = (state_q == ST_LOCKED) && init_done;
    if (active) begin
      bus.host_valid = sel_valid;
      bus.host_rs    = sel_txn.rs;
      bus.host_data  = sel_txn.data;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        bus.req_ready[i] = (grant_q == IW'(i)) && bus.host_ready;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (init_done && pick_any) begin
          state_d  = ST_LOCKED;
          grant_d  = pick_idx;
          wd_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (!init_done) begin
          state_d  = ST_IDLE;
          wd_cnt_d = '0;
        end else if (sel_valid) begin
          wd_cnt_d = '0;
          if (bus.host_ready && sel_last) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
          end
        end else if (wd_cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          tmo_d        = 1'b1;
          wd_cnt_d     = '0;
        end else if (wd_cnt_q != '1) begin
          wd_cnt_d = wd_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign grant_id      = grant_q;
  assign busy          = (state_q == ST_LOCKED);
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_lcd_txn_arbiter.sv
// Directed bench for lcd_txn_arbiter: packet locking, round-robin order, back-pressure,
// watchdog release, init_done drop and asynchronous reset.
module tb_lcd_txn_arbiter;
  import lcd_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned LT = 16;

  logic       MAX10_CLK1_50 = 1'b0;
  logic       rst_n;
  logic       init_done;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_pulse;

  int n_cmp = 0;
  int n_err = 0;

  lcd_txn_arbiter_if #(.N_REQ(N)) bus ();

  lcd_txn_arbiter #(
    .N_REQ        (N),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .rst_n         (rst_n),
    .init_done     (init_done),
    .bus           (bus.master),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MAX10_CLK1_50);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic rs, input logic [7:0] d,
                         input logic last);
    bus.req_valid[i]           = v;
    bus.req_txn[i*LCD_TXN_W +: LCD_TXN_W] = {rs, d};
    bus.req_last[i]            = last;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_txn   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int exp_order [5] = '{0, 1, 2, 0, 1};

  initial begin
    rst_n          = 1'b0;
    init_done      = 1'b0;
    bus.req_valid  = '0;
    bus.req_txn    = '0;
    bus.req_last   = '0;
    bus.host_ready = 1'b0;
    tick();
    #1;
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hvalid", 32'(bus.host_valid), 0);
    chk("rst_rready", 32'(bus.req_ready), 0);
    chk("rst_tmo", 32'(timeout_pulse), 0);

    // Two-beat packet from req0.
    tick();
    rst_n          = 1'b1;
    init_done      = 1'b1;
    bus.host_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 8'h80, 1'b0);
    #1;
    chk("t1_idle_hvalid", 32'(bus.host_valid), 0);
    chk("t1_idle_rready", 32'(bus.req_ready), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    tick();
    #1;
    chk("t1_grant", 32'(grant_id), 0);
    chk("t1_busy_a", 32'(busy), 1);
    chk("t1_hvalid_a", 32'(bus.host_valid), 1);
    chk("t1_data_a", 32'(bus.host_data), 32'h80);
    chk("t1_rs_a", 32'(bus.host_rs), 0);
    chk("t1_rready_a", 32'(bus.req_ready), 32'b001);
    tick();
    set_req(0, 1'b1, 1'b1, 8'h41, 1'b1);
    #1;
    chk("t1_busy_b", 32'(busy), 1);
    chk("t1_data_b", 32'(bus.host_data), 32'h41);
    chk("t1_rs_b", 32'(bus.host_rs), 1);
    tick();
    set_req(0, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("t1_end_busy", 32'(busy), 0);
    chk("t1_end_hvalid", 32'(bus.host_valid), 0);

    // All three requesters with continuous one-beat packets.
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 8'(8'h10 + i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("t2_grant", 32'(grant_id), 32'(exp_order[k]));
      chk("t2_data", 32'(bus.host_data), 32'h10 + 32'(exp_order[k]));
      chk("t2_busy", 32'(busy), 1);
      tick();
      #1;
      chk("t2_gap_busy", 32'(busy), 0);
      chk("t2_gap_hvalid", 32'(bus.host_valid), 0);
    end
    bus.req_valid = '0;

    // req1 three-beat packet; req0 arrives mid-packet and must wait.
    set_req(1, 1'b1, 1'b0, 8'hA1, 1'b0);
    tick();
    #1;
    chk("t3_grant1", 32'(grant_id), 1);
    chk("t3_data1", 32'(bus.host_data), 32'hA1);
    set_req(0, 1'b1, 1'b1, 8'h55, 1'b1);
    #1;
    chk("t3_hold_data", 32'(bus.host_data), 32'hA1);
    chk("t3_rready", 32'(bus.req_ready), 32'b010);
    tick();
    set_req(1, 1'b1, 1'b0, 8'hA2, 1'b0);
    #1;
    chk("t3_grant2", 32'(grant_id), 1);
    chk("t3_data2", 32'(bus.host_data), 32'hA2);
    tick();
    set_req(1, 1'b1, 1'b0, 8'hA3, 1'b1);
    #1;
    chk("t3_grant3", 32'(grant_id), 1);
    chk("t3_data3", 32'(bus.host_data), 32'hA3);
    tick();
    set_req(1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("t3_gap_busy", 32'(busy), 0);
    tick();
    #1;
    chk("t3_req0_grant", 32'(grant_id), 0);
    chk("t3_req0_data", 32'(bus.host_data), 32'h55);
    tick();
    set_req(0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Back-pressure: host_ready low for 20 cycles mid-packet.
    bus.host_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 8'hC3, 1'b0);
    tick();
    #1;
    chk("t4_grant", 32'(grant_id), 1);
    for (int k = 0; k < 20; k++) begin
      chk("t4_hvalid", 32'(bus.host_valid), 1);
      chk("t4_data", 32'(bus.host_data), 32'hC3);
      chk("t4_rready", 32'(bus.req_ready), 0);
      chk("t4_tmo", 32'(timeout_pulse), 0);
      chk("t4_busy", 32'(busy), 1);
      tick();
      #1;
    end
    bus.host_ready = 1'b1;
    #1;
    chk("t4_rready_on", 32'(bus.req_ready), 32'b010);
    tick();
    set_req(1, 1'b1, 1'b1, 8'hC4, 1'b1);
    #1;
    chk("t4_data2", 32'(bus.host_data), 32'hC4);
    tick();
    set_req(1, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("t4_end_busy", 32'(busy), 0);

    // Watchdog: req2 stalls after one non-last beat; req0 pending.
    set_req(2, 1'b1, 1'b0, 8'hE0, 1'b0);
    tick();
    #1;
    chk("t5_grant", 32'(grant_id), 2);
    tick();
    set_req(2, 1'b0, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 1'b0, 8'h77, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      #1;
      chk("t5_wait_busy", 32'(busy), 1);
      chk("t5_wait_tmo", 32'(timeout_pulse), 0);
      chk("t5_wait_hvalid", 32'(bus.host_valid), 0);
    end
    tick();
    #1;
    chk("t5_rel_busy", 32'(busy), 0);
    chk("t5_rel_tmo", 32'(timeout_pulse), 1);
    chk("t5_rel_grant", 32'(grant_id), 2);
    tick();
    #1;
    chk("t5_next_tmo", 32'(timeout_pulse), 0);
    chk("t5_next_grant", 32'(grant_id), 0);
    chk("t5_next_busy", 32'(busy), 1);
    chk("t5_next_data", 32'(bus.host_data), 32'h77);
    tick();
    set_req(0, 1'b0, 1'b0, 8'h00, 1'b0);

    // init_done drop mid-packet, then asynchronous reset mid-packet.
    set_req(1, 1'b1, 1'b0, 8'h61, 1'b0);
    tick();
    #1;
    chk("t6_grant", 32'(grant_id), 1);
    init_done = 1'b0;
    #1;
    chk("t6_gate_hvalid", 32'(bus.host_valid), 0);
    chk("t6_gate_rready", 32'(bus.req_ready), 0);
    tick();
    #1;
    chk("t6_drop_busy", 32'(busy), 0);
    chk("t6_drop_tmo", 32'(timeout_pulse), 0);
    init_done = 1'b1;
    set_req(0, 1'b1, 1'b0, 8'h60, 1'b0);
    set_req(2, 1'b1, 1'b0, 8'h62, 1'b0);
    tick();
    #1;
    chk("t6_regrant", 32'(grant_id), 1);
    chk("t6_regrant_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_grant", 32'(grant_id), 0);
    chk("t6_rst_hvalid", 32'(bus.host_valid), 0);
    chk("t6_rst_rready", 32'(bus.req_ready), 0);
    chk("t6_rst_data", 32'(bus.host_data), 0);
    chk("t6_rst_tmo", 32'(timeout_pulse), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk("t6_post_grant", 32'(grant_id), 0);
    chk("t6_post_data", 32'(bus.host_data), 32'h60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
